mem_ls_stage: RTL and testbench

Dual-pipe MEM stage of the SPU pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM control, result and target-register fields of both issue pipes. It performs local-store loads and stores on 128-bit quadwords and selects the writeback value. It drives registered MEM/WB outputs to the register-file write port. In the default build a single-ported local store serialises a same-cycle double access by stalling upstream for one cycle.

---
 rtl/spu_mem_pkg.sv | 38 +++
 rtl/local_store.sv | 55 +++++
 rtl/mem_ls_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_ls_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spu_mem_pkg
//  Description : Shared types and constants for the SPU MEM stage and its
//                local store. Quadword and register-address typedefs, the
//                single-port FSM state encoding and the pending-request record.
//  Revision    : 1.0 - initial release
// ============================================================================
package spu_mem_pkg;

    // Default local-store geometry: 2048 quadwords = 32 KB.
    localparam int LS_DEPTH_DEFAULT = 2048;
    localparam int LS_AW_DEFAULT    = $clog2(LS_DEPTH_DEFAULT);

    // Quadword index container width inside the request record; wide enough
    // for any practical LS_DEPTH override, the stage slices what it needs.
    localparam int QIDX_W = 32;

    typedef logic [127:0] quadword_t;
    typedef logic [6:0]   regaddr_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } ls_state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic              toReg;
        logic              wen;
        logic [QIDX_W-1:0] addr;
        quadword_t         data;
        regaddr_t          rt;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/local_store.sv
`default_nettype none
// ============================================================================
//  Module      : local_store
//  Description : LS_DEPTH x 128-bit local store. Combinational read, write on
//                the rising clock edge; a read on the port being written sees
//                the old data. Contents are never reset.
//  Ports       : clk              clock
//                we0/addr0/wdata0 port 0 write enable, quadword index, data
//                rdata0           port 0 read data
//                we1/addr1/wdata1/rdata1  second port (DUAL_PORT_LS_EN only)
//  Config      : DUAL_PORT_LS_EN adds port 1. Port 1 wins a same-address
//                write; a port 1 read of the address port 0 is writing this
//                cycle returns port 0's write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module local_store
    import spu_mem_pkg::*;
#(
    parameter int LS_DEPTH = LS_DEPTH_DEFAULT,
    parameter int LS_AW    = $clog2(LS_DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [LS_AW-1:0] addr0,
    input  quadword_t        wdata0,
    output quadword_t        rdata0
`ifdef DUAL_PORT_LS_EN
    ,
    input  logic             we1,
    input  logic [LS_AW-1:0] addr1,
    input  quadword_t        wdata1,
    output quadword_t        rdata1
`endif
);

    quadword_t mem [LS_DEPTH];

    assign rdata0 = mem[addr0];

`ifdef DUAL_PORT_LS_EN
    // Port 1 logically follows port 0 within the cycle.
    assign rdata1 = (we0 && (addr0 == addr1)) ? wdata0 : mem[addr1];

    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= wdata0;
        if (we1) mem[addr1] <= wdata1;
    end
`else
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= wdata0;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_ls_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ls_stage
//  Description : Dual-pipe MEM stage. Performs local-store quadword loads and
//                stores for both issue pipes, selects the writeback value and
//                registers the MEM/WB outputs. With a single-ported store a
//                same-cycle double access is split over two cycles (IDLE ->
//                SECOND) while stall_MEM holds upstream for one cycle.
//  Ports       : clk, reset (synchronous, active low)
//                *_MEM1/2  EX/MEM control, result, store data, destination
//                stall_MEM combinational upstream hold
//                *_WB1/2   registered writeback enable, destination, data
//  Config      : DUAL_PORT_LS_EN - two-port store, no FSM, stall_MEM tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ls_stage
    import spu_mem_pkg::*;
#(
    parameter int LS_DEPTH = LS_DEPTH_DEFAULT,
    parameter int LS_AW    = $clog2(LS_DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memToReg_MEM1,
    input  logic         memToReg_MEM2,
    input  logic         regWriteEnable_MEM1,
    input  logic         regWriteEnable_MEM2,
    input  logic         memRead_MEM1,
    input  logic         memRead_MEM2,
    input  logic         memWrite_MEM1,
    input  logic         memWrite_MEM2,
    input  logic [127:0] result_MEM1,
    input  logic [127:0] result_MEM2,
    input  logic [127:0] storeData_MEM1,
    input  logic [127:0] storeData_MEM2,
    input  logic [6:0]   registerRT_MEM1,
    input  logic [6:0]   registerRT_MEM2,
    output logic         stall_MEM,
    output logic         regWriteEnable_WB1,
    output logic         regWriteEnable_WB2,
    output logic [6:0]   registerRT_WB1,
    output logic [6:0]   registerRT_WB2,
    output logic [127:0] writeData_WB1,
    output logic [127:0] writeData_WB2
);

`ifdef DUAL_PORT_LS_EN
    // Reads are unconditional, so the read strobes carry no information here.
    logic      unused_read_ctrl;
    quadword_t rdata1;
    quadword_t rdata2;

    assign unused_read_ctrl = memRead_MEM1 ^ memRead_MEM2;
    assign stall_MEM        = 1'b0;

    local_store #(
        .LS_DEPTH (LS_DEPTH),
        .LS_AW    (LS_AW)
    ) u_local_store (
        .clk    (clk),
        .we0    (reset & memWrite_MEM1),
        .addr0  (result_MEM1[LS_AW+3:4]),
        .wdata0 (storeData_MEM1),
        .rdata0 (rdata1),
        .we1    (reset & memWrite_MEM2),
        .addr1  (result_MEM2[LS_AW+3:4]),
        .wdata1 (storeData_MEM2),
        .rdata1 (rdata2)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            regWriteEnable_WB1 <= 1'b0;
            registerRT_WB1     <= '0;
            writeData_WB1      <= '0;
            regWriteEnable_WB2 <= 1'b0;
            registerRT_WB2     <= '0;
            writeData_WB2      <= '0;
        end else begin
            regWriteEnable_WB1 <= regWriteEnable_MEM1;
            registerRT_WB1     <= registerRT_MEM1;
            writeData_WB1      <= memToReg_MEM1 ? rdata1 : result_MEM1;
            regWriteEnable_WB2 <= regWriteEnable_MEM2;
            registerRT_WB2     <= registerRT_MEM2;
            writeData_WB2      <= memToReg_MEM2 ? rdata2 : result_MEM2;
        end
    end
`else
    ls_state_t        state;
    mem_req_t         pend;
    quadword_t        pend_result;
    mem_req_t         req2;
    logic             acc1;
    logic             acc2;
    logic             conflict;
    logic             port_we;
    logic [LS_AW-1:0] port_addr;
    quadword_t        port_wdata;
    quadword_t        port_rdata;

    assign acc1      = memRead_MEM1 | memWrite_MEM1;
    assign acc2      = memRead_MEM2 | memWrite_MEM2;
    assign conflict  = (state == IDLE) && acc1 && acc2;
    // Gated by reset so the hold request is quiet while the stage is in reset.
    assign stall_MEM = reset && conflict;

    always_comb begin
        req2       = '0;
        req2.read  = memRead_MEM2;
        req2.write = memWrite_MEM2;
        req2.toReg = memToReg_MEM2;
        req2.wen   = regWriteEnable_MEM2;
        req2.addr  = {{(QIDX_W-LS_AW){1'b0}}, result_MEM2[LS_AW+3:4]};
        req2.data  = storeData_MEM2;
        req2.rt    = registerRT_MEM2;
    end

    // Single port owner: latched pipe2 in SECOND, else pipe1 before pipe2.
    always_comb begin
        port_we    = 1'b0;
        port_addr  = '0;
        port_wdata = '0;
        if (state == SECOND) begin
            port_we    = pend.write;
            port_addr  = pend.addr[LS_AW-1:0];
            port_wdata = pend.data;
        end else if (acc1) begin
            port_we    = memWrite_MEM1;
            port_addr  = result_MEM1[LS_AW+3:4];
            port_wdata = storeData_MEM1;
        end else if (acc2) begin
            port_we    = memWrite_MEM2;
            port_addr  = result_MEM2[LS_AW+3:4];
            port_wdata = storeData_MEM2;
        end
        // A reset edge must not commit anything, including a pending store.
        if (!reset) port_we = 1'b0;
    end

    local_store #(
        .LS_DEPTH (LS_DEPTH),
        .LS_AW    (LS_AW)
    ) u_local_store (
        .clk    (clk),
        .we0    (port_we),
        .addr0  (port_addr),
        .wdata0 (port_wdata),
        .rdata0 (port_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            pend               <= '0;
            pend_result        <= '0;
            regWriteEnable_WB1 <= 1'b0;
            registerRT_WB1     <= '0;
            writeData_WB1      <= '0;
            regWriteEnable_WB2 <= 1'b0;
            registerRT_WB2     <= '0;
            writeData_WB2      <= '0;
        end else if (state == SECOND) begin
            regWriteEnable_WB1 <= 1'b0;
            registerRT_WB1     <= '0;
            writeData_WB1      <= '0;
            regWriteEnable_WB2 <= pend.wen;
            registerRT_WB2     <= pend.rt;
            writeData_WB2      <= pend.toReg ? port_rdata : pend_result;
            pend               <= '0;
            pend_result        <= '0;
            state              <= IDLE;
        end else begin
            regWriteEnable_WB1 <= regWriteEnable_MEM1;
            registerRT_WB1     <= registerRT_MEM1;
            writeData_WB1      <= memToReg_MEM1 ? port_rdata : result_MEM1;
            if (conflict) begin
                regWriteEnable_WB2 <= 1'b0;
                registerRT_WB2     <= '0;
                writeData_WB2      <= '0;
                pend               <= req2;
                pend_result        <= result_MEM2;
                state              <= SECOND;
            end else begin
                regWriteEnable_WB2 <= regWriteEnable_MEM2;
                registerRT_WB2     <= registerRT_MEM2;
                writeData_WB2      <= memToReg_MEM2 ? port_rdata : result_MEM2;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ls_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ls_stage
//  Description : Self-checking bench for mem_ls_stage: directed vector table,
//                a reset-during-SECOND sequence and randomized traffic checked
//                against a transaction-level reference model.
//  Config      : honours DUAL_PORT_LS_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ls_stage;
    import spu_mem_pkg::*;

    localparam int DEPTH = LS_DEPTH_DEFAULT;
`ifdef DUAL_PORT_LS_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic rd; logic wr; logic tr; logic we;
        logic [6:0] rt; logic [127:0] res; logic [127:0] sd;
    } pipe_t;
    typedef struct packed { logic wen; logic [6:0] rt; logic [127:0] data; } wb_t;
    typedef struct packed {
        logic rst_n; pipe_t p1; pipe_t p2; logic stall; wb_t w1; wb_t w2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic memToReg_MEM1, memToReg_MEM2, regWriteEnable_MEM1, regWriteEnable_MEM2;
    logic memRead_MEM1, memRead_MEM2, memWrite_MEM1, memWrite_MEM2;
    logic [127:0] result_MEM1, result_MEM2, storeData_MEM1, storeData_MEM2;
    logic [6:0] registerRT_MEM1, registerRT_MEM2;
    logic stall_MEM, regWriteEnable_WB1, regWriteEnable_WB2;
    logic [6:0] registerRT_WB1, registerRT_WB2;
    logic [127:0] writeData_WB1, writeData_WB2;

    int checks = 0;
    int failures = 0;

    // Reference model state: sparse memory image and a deferred pipe2 access.
    logic [127:0] mem_ref [int];
    pipe_t pend;
    bit    pend_valid = 1'b0;

    always #5 clk = ~clk;

    mem_ls_stage dut (
        .clk(clk), .reset(reset),
        .memToReg_MEM1(memToReg_MEM1), .memToReg_MEM2(memToReg_MEM2),
        .regWriteEnable_MEM1(regWriteEnable_MEM1), .regWriteEnable_MEM2(regWriteEnable_MEM2),
        .memRead_MEM1(memRead_MEM1), .memRead_MEM2(memRead_MEM2),
        .memWrite_MEM1(memWrite_MEM1), .memWrite_MEM2(memWrite_MEM2),
        .result_MEM1(result_MEM1), .result_MEM2(result_MEM2),
        .storeData_MEM1(storeData_MEM1), .storeData_MEM2(storeData_MEM2),
        .registerRT_MEM1(registerRT_MEM1), .registerRT_MEM2(registerRT_MEM2),
        .stall_MEM(stall_MEM),
        .regWriteEnable_WB1(regWriteEnable_WB1), .regWriteEnable_WB2(regWriteEnable_WB2),
        .registerRT_WB1(registerRT_WB1), .registerRT_WB2(registerRT_WB2),
        .writeData_WB1(writeData_WB1), .writeData_WB2(writeData_WB2)
    );

    // ---------------- stimulus helpers ----------------
    function automatic pipe_t nop();
        pipe_t p = '0;
        return p;
    endfunction
    function automatic pipe_t alu(input logic [127:0] r, input logic [6:0] rt);
        pipe_t p = '0;
        p.we = 1'b1; p.rt = rt; p.res = r;
        return p;
    endfunction
    function automatic pipe_t st(input logic [127:0] a, input logic [127:0] d);
        pipe_t p = '0;
        p.wr = 1'b1; p.res = a; p.sd = d;
        return p;
    endfunction
    function automatic pipe_t ld(input logic [127:0] a, input logic [6:0] rt);
        pipe_t p = '0;
        p.rd = 1'b1; p.tr = 1'b1; p.we = 1'b1; p.rt = rt; p.res = a;
        return p;
    endfunction
    function automatic wb_t wb(input logic e, input logic [6:0] rt, input logic [127:0] d);
        wb_t w;
        w.wen = e; w.rt = rt; w.data = d;
        return w;
    endfunction
    function automatic vec_t mk(input logic r, input pipe_t a, input pipe_t b,
                                input logic s, input wb_t w1, input wb_t w2);
        vec_t v;
        v.rst_n = r; v.p1 = a; v.p2 = b; v.stall = s; v.w1 = w1; v.w2 = w2;
        return v;
    endfunction
    function automatic logic [127:0] rand_q();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    function automatic pipe_t rand_pipe();
        pipe_t p = '0;
        int k;
        logic [127:0] a;
        k = $urandom_range(0, 4);
        a = 128'(32'h200 + $urandom_range(0, 7) * 16 + $urandom_range(0, 1) * DEPTH * 16
                 + $urandom_range(0, 15));
        case (k)
            0: begin p.we = 1'($urandom); p.rt = 7'($urandom); p.res = rand_q(); end
            1: p = ld(a, 7'($urandom));
            2: p = st(a, rand_q());
            3: begin p = ld(a, 7'($urandom)); p.wr = 1'b1; p.sd = rand_q(); end
            default: p = nop();
        endcase
        return p;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit is_mem(input pipe_t p);
        return p.rd || p.wr;
    endfunction
    // One memory access: read sees the contents before this access's write.
    function automatic wb_t service(input pipe_t p);
        wb_t w;
        int idx;
        logic [127:0] old;
        idx = int'(p.res[31:4]) % DEPTH;
        old = mem_ref.exists(idx) ? mem_ref[idx] : '0;
        if (p.wr) mem_ref[idx] = p.sd;
        w.wen = p.we; w.rt = p.rt; w.data = p.tr ? old : p.res;
        return w;
    endfunction
    function automatic vec_t model(input logic r, input pipe_t a, input pipe_t b);
        vec_t v = '0;
        v.rst_n = r; v.p1 = a; v.p2 = b;
        if (!r) begin
            pend_valid = 1'b0;
            return v;
        end
        if (DUAL) begin
            v.w1 = service(a);
            v.w2 = service(b);
        end else if (pend_valid) begin
            v.w2 = service(pend);
            pend_valid = 1'b0;
        end else if (is_mem(a) && is_mem(b)) begin
            v.stall = 1'b1;
            v.w1 = service(a);
            pend = b;
            pend_valid = 1'b1;
        end else begin
            v.w1 = service(a);
            v.w2 = service(b);
        end
        return v;
    endfunction

    // ---------------- drive / check ----------------
    task automatic drive(input vec_t v);
        reset = v.rst_n;
        memToReg_MEM1 = v.p1.tr; regWriteEnable_MEM1 = v.p1.we;
        memRead_MEM1 = v.p1.rd;  memWrite_MEM1 = v.p1.wr;
        result_MEM1 = v.p1.res;  storeData_MEM1 = v.p1.sd; registerRT_MEM1 = v.p1.rt;
        memToReg_MEM2 = v.p2.tr; regWriteEnable_MEM2 = v.p2.we;
        memRead_MEM2 = v.p2.rd;  memWrite_MEM2 = v.p2.wr;
        result_MEM2 = v.p2.res;  storeData_MEM2 = v.p2.sd; registerRT_MEM2 = v.p2.rt;
    endtask

    task automatic check_wb(input string tag, input string nm, input wb_t got, input wb_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s %s: got wen=%0b rt=%0d data=%h, expected wen=%0b rt=%0d data=%h",
                     tag, nm, got.wen, got.rt, got.data, exp.wen, exp.rt, exp.data);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        wb_t g1, g2;
        @(negedge clk);
        drive(v);
        #1;
        checks++;
        if (stall_MEM !== v.stall) begin
            failures++;
            $display("FAIL %s stall_MEM: got %b, expected %b", tag, stall_MEM, v.stall);
        end
        @(posedge clk);
        #1;
        g1 = {regWriteEnable_WB1, registerRT_WB1, writeData_WB1};
        g2 = {regWriteEnable_WB2, registerRT_WB2, writeData_WB2};
        check_wb(tag, "wb1", g1, v.w1);
        check_wb(tag, "wb2", g2, v.w2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        pipe_t a, b;
        logic r;
        logic held;
        logic [127:0] AA, Q1234, Q5555, QBEEF, Q1111, Q2222;
        wb_t z;
        AA = {16{8'hAA}}; Q1234 = 128'h1234; Q5555 = 128'h5555; QBEEF = 128'hBEEF;
        Q1111 = 128'h1111; Q2222 = 128'h2222;
        z = wb(1'b0, 7'd0, 128'd0);
        drive(mk(1'b0, nop(), nop(), 1'b0, z, z));

        // ---- directed table ----
        tbl.push_back(mk(1'b0, rand_pipe(), rand_pipe(), 1'b0, z, z));
        tbl.push_back(mk(1'b0, rand_pipe(), rand_pipe(), 1'b0, z, z));
        tbl.push_back(mk(1'b1, st(128'h40, AA), nop(), 1'b0, wb(0, 0, 128'h40), z));
        tbl.push_back(mk(1'b1, ld(128'h40, 7'd5), nop(), 1'b0, wb(1, 5, AA), z));
        // same-address conflict: pipe1 store, pipe2 load (held for the SECOND cycle)
        tbl.push_back(mk(1'b1, st(128'h80, Q1234), ld(128'h80, 7'd9), !DUAL,
                         wb(0, 0, 128'h80), DUAL ? wb(1, 9, Q1234) : z));
        tbl.push_back(mk(1'b1, st(128'h80, Q1234), ld(128'h80, 7'd9), 1'b0,
                         DUAL ? wb(0, 0, 128'h80) : z, wb(1, 9, Q1234)));
        // wrap and ignored low nibble
        tbl.push_back(mk(1'b1, st(128'(DEPTH * 16 + 16), Q5555), nop(), 1'b0,
                         wb(0, 0, 128'(DEPTH * 16 + 16)), z));
        tbl.push_back(mk(1'b1, ld(128'h1F, 7'd3), nop(), 1'b0, wb(1, 3, Q5555), z));
        tbl.push_back(mk(1'b1, alu(128'd7, 7'd1), alu(128'd9, 7'd2), 1'b0,
                         wb(1, 1, 128'd7), wb(1, 2, 128'd9)));
        tbl.push_back(mk(1'b1, alu(128'd3, 7'd6), ld(128'h40, 7'd4), 1'b0,
                         wb(1, 6, 128'd3), wb(1, 4, AA)));
        // back-to-back conflicts; pipe1 load vs pipe2 store returns old data
        tbl.push_back(mk(1'b1, ld(128'h40, 7'd10), st(128'h40, QBEEF), !DUAL,
                         wb(1, 10, AA), DUAL ? wb(0, 0, 128'h40) : z));
        tbl.push_back(mk(1'b1, ld(128'h40, 7'd10), st(128'h40, QBEEF), 1'b0,
                         DUAL ? wb(1, 10, QBEEF) : z, wb(0, 0, 128'h40)));
        tbl.push_back(mk(1'b1, ld(128'h40, 7'd11), ld(128'h10, 7'd12), !DUAL,
                         wb(1, 11, QBEEF), DUAL ? wb(1, 12, Q5555) : z));
        tbl.push_back(mk(1'b1, ld(128'h40, 7'd11), ld(128'h10, 7'd12), 1'b0,
                         DUAL ? wb(1, 11, QBEEF) : z, wb(1, 12, Q5555)));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // ---- reset during SECOND drops the pending pipe2 store ----
        apply(mk(1'b1, st(128'h100, Q1111), nop(), 1'b0, wb(0, 0, 128'h100), z), "rst_pre");
        apply(mk(1'b1, ld(128'h40, 7'd1), st(128'h100, Q2222), !DUAL,
                 wb(1, 1, QBEEF), DUAL ? wb(0, 0, 128'h100) : z), "rst_conflict");
        apply(mk(1'b0, ld(128'h40, 7'd1), st(128'h100, Q2222), 1'b0, z, z), "rst_second");
        apply(mk(1'b1, ld(128'h100, 7'd7), nop(), 1'b0,
                 wb(1, 7, DUAL ? Q2222 : Q1111), z), "rst_after");

        // ---- randomized traffic against the reference model ----
        pend_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v = model(1'b1, st(128'(32'h200 + k * 16), rand_q()), nop());
            apply(v, $sformatf("init%0d", k));
        end
        held = 1'b0;
        a = nop();
        b = nop();
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 39) != 0);
            // Upstream holds the pair while stall_MEM is asserted.
            if (!held) begin
                a = rand_pipe();
                b = rand_pipe();
            end
            v = model(r, a, b);
            apply(v, $sformatf("rand%0d", i));
            held = v.stall;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
